// File: rtl/sram_rw_r_arbiter_if.sv
// Bus bundle between requesters A/B, the RW_R SRAM wrapper and the arbiter.
// The arbiter uses the slave view; the surrounding environment uses master.
interface sram_rw_r_arbiter_if #(
    parameter int BYTE_COUNT   = 4,
    parameter int ADDRESS_SIZE = 9
);
    localparam int WORD_SIZE = 8 * BYTE_COUNT;

    logic                    aRequest;
    logic                    aWriteEnable;
    logic [BYTE_COUNT-1:0]   aWriteMask;
    logic [ADDRESS_SIZE-1:0] aAddress;
    logic [WORD_SIZE-1:0]    aDataWrite;
    logic                    aReady;
    logic [WORD_SIZE-1:0]    aDataRead;

    logic                    bRequest;
    logic                    bWriteEnable;
    logic [BYTE_COUNT-1:0]   bWriteMask;
    logic [ADDRESS_SIZE-1:0] bAddress;
    logic [WORD_SIZE-1:0]    bDataWrite;
    logic                    bReady;
    logic [WORD_SIZE-1:0]    bDataRead;

    logic                    sramPrimarySelect;
    logic                    sramPrimaryWriteEnable;
    logic [BYTE_COUNT-1:0]   sramPrimaryWriteMask;
    logic [ADDRESS_SIZE-1:0] sramPrimaryAddress;
    logic [WORD_SIZE-1:0]    sramPrimaryDataWrite;
    logic [WORD_SIZE-1:0]    sramPrimaryDataRead;

    logic                    secondaryRequest;
    logic [ADDRESS_SIZE-1:0] secondaryAddress;
    logic [WORD_SIZE-1:0]    secondaryDataRead;
    logic                    secondaryReadValid;
    logic                    sramSecondarySelect;
    logic [ADDRESS_SIZE-1:0] sramSecondaryAddress;
    logic [WORD_SIZE-1:0]    sramSecondaryDataRead;

    modport slave (
        input  aRequest, aWriteEnable, aWriteMask, aAddress, aDataWrite,
        output aReady, aDataRead,
        input  bRequest, bWriteEnable, bWriteMask, bAddress, bDataWrite,
        output bReady, bDataRead,
        output sramPrimarySelect, sramPrimaryWriteEnable, sramPrimaryWriteMask,
        output sramPrimaryAddress, sramPrimaryDataWrite,
        input  sramPrimaryDataRead,
        input  secondaryRequest, secondaryAddress,
        output secondaryDataRead, secondaryReadValid,
        output sramSecondarySelect, sramSecondaryAddress,
        input  sramSecondaryDataRead
    );

    modport master (
        output aRequest, aWriteEnable, aWriteMask, aAddress, aDataWrite,
        input  aReady, aDataRead,
        output bRequest, bWriteEnable, bWriteMask, bAddress, bDataWrite,
        input  bReady, bDataRead,
        input  sramPrimarySelect, sramPrimaryWriteEnable, sramPrimaryWriteMask,
        input  sramPrimaryAddress, sramPrimaryDataWrite,
        output sramPrimaryDataRead,
        output secondaryRequest, secondaryAddress,
        input  secondaryDataRead, secondaryReadValid,
        input  sramSecondarySelect, sramSecondaryAddress,
        output sramSecondaryDataRead
    );
endinterface

// File: rtl/sram_rw_r_arbiter.sv
// Two-requester arbiter for the RW_R SRAM primary port plus secondary read passthrough.
// Define SRAM_ARBITER_ROUND_ROBIN_EN for round-robin contention; default is fixed A priority.
module sram_rw_r_arbiter #(
    parameter int BYTE_COUNT   = 4,
    parameter int ADDRESS_SIZE = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_rw_r_arbiter_if.slave    bus
);
    localparam int WORD_SIZE = 8 * BYTE_COUNT;

    typedef enum logic {S_IDLE, S_RESPOND} state_t;

    state_t r_state;
    logic   r_grantB;
    logic   r_aReady;
    logic   r_bReady;
    logic   r_secondaryReadValid;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    logic   r_lastGrantB;
`endif

    logic w_anyRequest;
    logic w_pickB;
    logic w_select;

    always_comb begin
        w_anyRequest = bus.aRequest | bus.bRequest;
        w_pickB      = bus.bRequest;
        if (bus.aRequest && bus.bRequest) begin
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
            w_pickB = ~r_lastGrantB;
`else
            w_pickB = 1'b0;
`endif
        end
    end

    // Strobe only from IDLE; gating with rst keeps the SRAM quiet while held in reset.
    assign w_select = (r_state == S_IDLE) && w_anyRequest && rst;

    always_comb begin
        bus.sramPrimarySelect      = w_select;
        bus.sramPrimaryWriteEnable = 1'b0;
        bus.sramPrimaryWriteMask   = '0;
        bus.sramPrimaryAddress     = '0;
        bus.sramPrimaryDataWrite   = '0;
        if (w_select) begin
            if (w_pickB) begin
                bus.sramPrimaryWriteEnable = bus.bWriteEnable;
                bus.sramPrimaryWriteMask   = bus.bWriteMask;
                bus.sramPrimaryAddress     = bus.bAddress;
                bus.sramPrimaryDataWrite   = bus.bDataWrite;
            end else begin
                bus.sramPrimaryWriteEnable = bus.aWriteEnable;
                bus.sramPrimaryWriteMask   = bus.aWriteMask;
                bus.sramPrimaryAddress     = bus.aAddress;
                bus.sramPrimaryDataWrite   = bus.aDataWrite;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_grantB <= 1'b0;
            r_aReady <= 1'b0;
            r_bReady <= 1'b0;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
            r_lastGrantB <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyRequest) begin
                        r_state  <= S_RESPOND;
                        r_grantB <= w_pickB;
                        r_aReady <= ~w_pickB;
                        r_bReady <= w_pickB;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
                        r_lastGrantB <= w_pickB;
`endif
                    end
                end
                default: begin
                    // Access already committed; ready pulses regardless of request.
                    r_state  <= S_IDLE;
                    r_aReady <= 1'b0;
                    r_bReady <= 1'b0;
                end
            endcase
        end
    end

    assign bus.aReady    = r_aReady;
    assign bus.bReady    = r_bReady;
    assign bus.aDataRead = (r_aReady && !r_grantB) ? bus.sramPrimaryDataRead : {WORD_SIZE{1'b0}};
    assign bus.bDataRead = (r_bReady &&  r_grantB) ? bus.sramPrimaryDataRead : {WORD_SIZE{1'b0}};

    // Secondary read port runs independently of the primary FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_secondaryReadValid <= 1'b0;
        else      r_secondaryReadValid <= bus.secondaryRequest;
    end

    assign bus.sramSecondarySelect  = bus.secondaryRequest;
    assign bus.sramSecondaryAddress = bus.secondaryAddress;
    assign bus.secondaryReadValid   = r_secondaryReadValid;
    assign bus.secondaryDataRead    = r_secondaryReadValid ? bus.sramSecondaryDataRead
                                                           : {WORD_SIZE{1'b0}};
endmodule

// File: tb/tb_sram_rw_r_arbiter.sv
// Directed self-checking bench for sram_rw_r_arbiter with a behavioural RW_R SRAM.
module tb_sram_rw_r_arbiter;
    localparam int BC = 4;
    localparam int AS = 9;
    localparam int WS = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic lastB  = 1'b0;

    always #5 clk = ~clk;

    sram_rw_r_arbiter_if #(.BYTE_COUNT(BC), .ADDRESS_SIZE(AS)) bus ();
    sram_rw_r_arbiter #(.BYTE_COUNT(BC), .ADDRESS_SIZE(AS)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [WS-1:0] mem [0:(1<<AS)-1];

    // SRAM model: read data appears the cycle after select, byte-masked writes.
    always @(posedge clk) begin
        if (bus.sramPrimarySelect) begin
            if (bus.sramPrimaryWriteEnable) begin
                for (int i = 0; i < BC; i++)
                    if (bus.sramPrimaryWriteMask[i])
                        mem[bus.sramPrimaryAddress][8*i +: 8] <= bus.sramPrimaryDataWrite[8*i +: 8];
            end else begin
                bus.sramPrimaryDataRead <= mem[bus.sramPrimaryAddress];
            end
        end
        if (bus.sramSecondarySelect)
            bus.sramSecondaryDataRead <= mem[bus.sramSecondaryAddress];
    end

    task automatic drive_a(input logic req, input logic we, input logic [BC-1:0] m,
                           input logic [AS-1:0] a, input logic [WS-1:0] d);
        bus.aRequest = req; bus.aWriteEnable = we; bus.aWriteMask = m;
        bus.aAddress = a;   bus.aDataWrite = d;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [BC-1:0] m,
                           input logic [AS-1:0] a, input logic [WS-1:0] d);
        bus.bRequest = req; bus.bWriteEnable = we; bus.bWriteMask = m;
        bus.bAddress = a;   bus.bDataWrite = d;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.aReady, bus.bReady, bus.secondaryReadValid, bus.sramPrimarySelect} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.aReady, bus.bReady, bus.secondaryReadValid, bus.sramPrimarySelect});
        end
        checks++;
        if ({bus.aDataRead, bus.bDataRead, bus.secondaryDataRead} !== '0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h s=%h want 0", bus.aDataRead, bus.bDataRead,
                     bus.secondaryDataRead);
        end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_read_a;
        @(posedge clk); #1 drive_a(1, 0, 4'h0, 9'h005, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.sramPrimarySelect, bus.sramPrimaryWriteEnable, bus.sramPrimaryAddress} !== {2'b10, 9'h005}) begin
            errors++;
            $display("FAIL read_a_strobe: sel=%b we=%b addr=%h want sel=1 we=0 addr=005",
                     bus.sramPrimarySelect, bus.sramPrimaryWriteEnable, bus.sramPrimaryAddress);
        end
        @(negedge clk);
        checks++;
        if ({bus.aReady, bus.bReady, bus.sramPrimarySelect} !== 3'b100 || bus.aDataRead !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_a_ready: aR=%b bR=%b sel=%b data=%h want 1 0 0 deadbeef",
                     bus.aReady, bus.bReady, bus.sramPrimarySelect, bus.aDataRead);
        end
        @(posedge clk); #1 drive_a(0, 0, 4'h0, 9'h0, 32'h0);
        lastB = 1'b0;
    endtask

    task automatic test_write_b;
        @(posedge clk); #1 drive_b(1, 1, 4'b0011, 9'h1FF, 32'h12345678);
        @(negedge clk);
        checks++;
        if ({bus.sramPrimarySelect, bus.sramPrimaryWriteEnable, bus.sramPrimaryWriteMask} !== 6'b11_0011
            || bus.sramPrimaryDataWrite !== 32'h12345678 || bus.sramPrimaryAddress !== 9'h1FF) begin
            errors++;
            $display("FAIL write_b_strobe: sel=%b we=%b m=%b addr=%h d=%h want 1 1 0011 1ff 12345678",
                     bus.sramPrimarySelect, bus.sramPrimaryWriteEnable, bus.sramPrimaryWriteMask,
                     bus.sramPrimaryAddress, bus.sramPrimaryDataWrite);
        end
        @(negedge clk);
        checks++;
        if ({bus.bReady, bus.aReady} !== 2'b10) begin
            errors++;
            $display("FAIL write_b_ready: bR=%b aR=%b want 1 0", bus.bReady, bus.aReady);
        end
        @(posedge clk); #1 drive_b(1, 0, 4'h0, 9'h1FF, 32'h0);
        @(negedge clk); @(negedge clk);
        checks++;
        if (bus.bReady !== 1'b1 || bus.bDataRead !== 32'hAABB5678 || bus.aDataRead !== 32'h0) begin
            errors++;
            $display("FAIL write_b_readback: bR=%b data=%h aData=%h want 1 aabb5678 0",
                     bus.bReady, bus.bDataRead, bus.aDataRead);
        end
        @(posedge clk); #1 drive_b(0, 0, 4'h0, 9'h0, 32'h0);
        lastB = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [3:0] got_order, want_order;
        int         n_ready;
        logic       lb;
        n_ready = 0; got_order = '0; want_order = '0; lb = lastB;
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
            want_order[k] = ~lb;
`else
            want_order[k] = 1'b0;
`endif
            lb = want_order[k];
        end
        @(posedge clk); #1;
        drive_a(1, 0, 4'h0, 9'h005, 32'h0);
        drive_b(1, 0, 4'h0, 9'h1FF, 32'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.aReady || bus.bReady) begin
                if (n_ready < 4) got_order[n_ready] = bus.bReady;
                n_ready++;
            end
        end
        checks++;
        if (n_ready != 4 || got_order !== want_order) begin
            errors++;
            $display("FAIL back_to_back: readies=%0d order=%b want 4 order=%b (bit=1 means B)",
                     n_ready, got_order, want_order);
        end
        @(posedge clk); #1;
        drive_a(0, 0, 4'h0, 9'h0, 32'h0);
        drive_b(0, 0, 4'h0, 9'h0, 32'h0);
        lastB = lb;
    endtask

    task automatic test_drop_in_respond;
        @(posedge clk); #1 drive_a(1, 0, 4'h0, 9'h005, 32'h0);
        @(posedge clk); #1 drive_a(0, 0, 4'h0, 9'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.aReady !== 1'b1 || bus.aDataRead !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL drop_ready: aR=%b data=%h want 1 deadbeef", bus.aReady, bus.aDataRead);
        end
        @(negedge clk);
        checks++;
        if ({bus.aReady, bus.bReady, bus.sramPrimarySelect} !== 3'b000) begin
            errors++;
            $display("FAIL drop_idle: aR=%b bR=%b sel=%b want 000", bus.aReady, bus.bReady,
                     bus.sramPrimarySelect);
        end
        lastB = 1'b0;
    endtask

    task automatic test_reset_in_respond;
        @(posedge clk); #1 drive_b(1, 0, 4'h0, 9'h010, 32'h0);
        @(posedge clk); #1 rst = 1'b0; drive_b(0, 0, 4'h0, 9'h0, 32'h0);
        #1;
        checks++;
        if ({bus.aReady, bus.bReady, bus.sramPrimarySelect, bus.secondaryReadValid} !== 4'b0000
            || bus.bDataRead !== 32'h0) begin
            errors++;
            $display("FAIL rst_respond: aR=%b bR=%b sel=%b sv=%b bData=%h want all 0",
                     bus.aReady, bus.bReady, bus.sramPrimarySelect, bus.secondaryReadValid, bus.bDataRead);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.aReady, bus.bReady} !== 2'b00) begin
            errors++;
            $display("FAIL rst_lost_ready: aR=%b bR=%b want 00", bus.aReady, bus.bReady);
        end
        @(posedge clk); #1 drive_a(1, 0, 4'h0, 9'h005, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.sramPrimarySelect !== 1'b1) begin
            errors++;
            $display("FAIL rst_idle_select: sel=%b want 1", bus.sramPrimarySelect);
        end
        @(negedge clk);
        checks++;
        if (bus.aReady !== 1'b1 || bus.aDataRead !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rst_after_read: aR=%b data=%h want 1 deadbeef", bus.aReady, bus.aDataRead);
        end
        @(posedge clk); #1 drive_a(0, 0, 4'h0, 9'h0, 32'h0);
        lastB = 1'b0;
    endtask

    task automatic test_secondary;
        @(posedge clk); #1;
        drive_a(1, 1, 4'hF, 9'h020, 32'h0BADF00D);
        bus.secondaryRequest = 1'b1; bus.secondaryAddress = 9'h010;
        @(negedge clk);
        checks++;
        if ({bus.sramSecondarySelect, bus.sramSecondaryAddress, bus.secondaryReadValid} !== {1'b1, 9'h010, 1'b0}
            || bus.sramPrimarySelect !== 1'b1 || bus.sramPrimaryAddress !== 9'h020) begin
            errors++;
            $display("FAIL sec_strobe: ssel=%b saddr=%h sv=%b psel=%b paddr=%h want 1 010 0 1 020",
                     bus.sramSecondarySelect, bus.sramSecondaryAddress, bus.secondaryReadValid,
                     bus.sramPrimarySelect, bus.sramPrimaryAddress);
        end
        @(posedge clk); #1 bus.secondaryRequest = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.secondaryReadValid !== 1'b1 || bus.secondaryDataRead !== 32'hCAFEF00D || bus.aReady !== 1'b1) begin
            errors++;
            $display("FAIL sec_valid: sv=%b sdata=%h aR=%b want 1 cafef00d 1",
                     bus.secondaryReadValid, bus.secondaryDataRead, bus.aReady);
        end
        @(posedge clk); #1 drive_a(0, 0, 4'h0, 9'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.secondaryReadValid !== 1'b0 || bus.secondaryDataRead !== 32'h0) begin
            errors++;
            $display("FAIL sec_gate: sv=%b sdata=%h want 0 0", bus.secondaryReadValid, bus.secondaryDataRead);
        end
        @(posedge clk); #1 drive_a(1, 0, 4'h0, 9'h020, 32'h0);
        @(negedge clk); @(negedge clk);
        checks++;
        if (bus.aReady !== 1'b1 || bus.aDataRead !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL sec_a_write: aR=%b data=%h want 1 0badf00d", bus.aReady, bus.aDataRead);
        end
        @(posedge clk); #1 drive_a(0, 0, 4'h0, 9'h0, 32'h0);
        lastB = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AS); i++) mem[i] = '0;
        mem[9'h005] = 32'hDEADBEEF;
        mem[9'h1FF] = 32'hAABBCCDD;
        mem[9'h010] = 32'hCAFEF00D;
        drive_a(0, 0, 4'h0, 9'h0, 32'h0);
        drive_b(0, 0, 4'h0, 9'h0, 32'h0);
        bus.secondaryRequest = 1'b0;
        bus.secondaryAddress = '0;
        test_reset;
        test_read_a;
        test_write_b;
        test_back_to_back;
        test_drop_in_respond;
        test_reset_in_respond;
        test_secondary;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
